// File: rtl/rv32_pkg.sv
// rv32_pkg: constants and types shared by the register-file write-back path.
//   XLEN        datapath width
//   REG_ADDR_W  register index width
//   REG_ZERO    architectural x0, never written
//   wb_entry_t  {rd, data} pair carried from result source to the write port
package rv32_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: small FIFO of load results waiting for the register-file write port.
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset (flushes all entries)
//   i_push, i_entry  enqueue request and payload (ignored when full)
//   i_pop            dequeue request (ignored when empty)
//   o_head           oldest entry
//   o_full, o_empty  occupancy flags for the current cycle
//   o_full_next      occupancy flag after this cycle's push/pop
//   o_entry_rd       destination register of every slot
//   o_valid          per-slot valid bits, paired with o_entry_rd
module wb_fifo
    import rv32_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_push,
    input  wb_entry_t             i_entry,
    input  logic                  i_pop,
    output wb_entry_t             o_head,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_full_next,
    output logic [REG_ADDR_W-1:0] o_entry_rd [DEPTH],
    output logic [DEPTH-1:0]      o_valid
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    wb_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [DEPTH-1:0] r_valid;

    logic [CNT_W-1:0] w_count_d;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_comb begin
        w_count_d = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_d = r_count + 1'b1;
            2'b01:   w_count_d = r_count - 1'b1;
            default: w_count_d = r_count;
        endcase
    end

    assign o_full_next = (w_count_d == FULL_CNT);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= '0;
        end else begin
            // A push never targets the slot being popped: that would need a full FIFO.
            if (w_pop) begin
                r_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + 1'b1;
            end
            if (w_push) begin
                r_valid[r_wr_ptr] <= 1'b1;
                r_wr_ptr          <= r_wr_ptr + 1'b1;
            end
            r_count <= w_count_d;
        end
    end

    // Payload needs no reset; r_valid qualifies every use.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_entry;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_valid = r_valid;

    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            o_entry_rd[i] = r_mem[i].rd;
        end
    end

endmodule

// File: rtl/regfile_writeback.sv
// regfile_writeback: drives the single register-file write port from the ALU
// (fixed latency, always accepted) and the load unit (valid/ready, buffered).
// Ports:
//   i_clk, i_rst                    clock, synchronous active-high reset
//   i_alu_valid/i_alu_rd/i_alu_data ALU result, highest priority
//   i_ld_valid/i_ld_rd/i_ld_data    load result offer; o_ld_ready accepts it
//   o_alu_stall                     one-cycle request to hold off the ALU so a
//                                   starved load can drain
//   o_wb_en/o_wb_addr/o_wb_data     registered write port (en, addr_3, inp_buf_3)
//   i_rd_addr_1/2                   current read addresses
//   o_fwd_hit_1/2, o_fwd_data_1/2   write-in-flight bypass for each read port
//   o_pend_1/2                      read address matches a buffered, unwritten load
// XLEN must match rv32_pkg::XLEN, since buffered entries use wb_entry_t.
module regfile_writeback
    import rv32_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_alu_valid,
    input  logic [REG_ADDR_W-1:0] i_alu_rd,
    input  logic [XLEN-1:0]       i_alu_data,
    input  logic                  i_ld_valid,
    output logic                  o_ld_ready,
    input  logic [REG_ADDR_W-1:0] i_ld_rd,
    input  logic [XLEN-1:0]       i_ld_data,
    output logic                  o_alu_stall,
    output logic                  o_wb_en,
    output logic [REG_ADDR_W-1:0] o_wb_addr,
    output logic [XLEN-1:0]       o_wb_data,
    input  logic [REG_ADDR_W-1:0] i_rd_addr_1,
    input  logic [REG_ADDR_W-1:0] i_rd_addr_2,
    output logic                  o_fwd_hit_1,
    output logic                  o_fwd_hit_2,
    output logic [XLEN-1:0]       o_fwd_data_1,
    output logic [XLEN-1:0]       o_fwd_data_2,
    output logic                  o_pend_1,
    output logic                  o_pend_2
);

    localparam int unsigned SCNT_W = $clog2(STARVE_LIMIT) + 1;
    localparam logic [SCNT_W-1:0] STARVE_LAST = SCNT_W'(STARVE_LIMIT - 1);

    // Registered state
    logic                  r_wb_en;
    logic [REG_ADDR_W-1:0] r_wb_addr;
    logic [XLEN-1:0]       r_wb_data;
    logic                  r_alu_stall;
    logic                  r_ld_ready;
    logic [SCNT_W-1:0]     r_starve_cnt;

    // Buffer interface
    wb_entry_t             w_head;
    wb_entry_t             w_ld_entry;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_full_next;
    logic [REG_ADDR_W-1:0] w_entry_rd [DEPTH];
    logic [DEPTH-1:0]      w_valid;
    logic                  w_push;
    logic                  w_pop;

    // Source select and next state
    wb_entry_t             w_src;
    logic                  w_src_valid;
    logic                  w_wb_en_d;
    logic                  w_wait;
    logic                  w_stall_d;
    logic [SCNT_W-1:0]     w_starve_d;
    logic                  w_pend_1;
    logic                  w_pend_2;

    assign w_ld_entry.rd   = i_ld_rd;
    assign w_ld_entry.data = i_ld_data;

    // r_ld_ready already mirrors !full; the extra term keeps the FIFO safe
    // against a push arriving while full even if a pop lands in the same cycle.
    assign w_push = i_ld_valid && r_ld_ready && !w_full;
    assign w_pop  = !i_alu_valid && !w_empty;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (w_push),
        .i_entry     (w_ld_entry),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_full_next (w_full_next),
        .o_entry_rd  (w_entry_rd),
        .o_valid     (w_valid)
    );

    always_comb begin
        w_src       = '0;
        w_src_valid = 1'b0;
        if (i_alu_valid) begin
            w_src_valid = 1'b1;
            w_src.rd    = i_alu_rd;
            w_src.data  = i_alu_data;
        end else if (w_pop) begin
            w_src_valid = 1'b1;
            w_src       = w_head;
        end
    end

    // x0 results are consumed but never reach the port.
    assign w_wb_en_d = w_src_valid && (w_src.rd != REG_ZERO);

    // Starvation guard: count cycles the head is left waiting; on the last
    // allowed one, stall the ALU for a cycle so the head drains.
    assign w_wait     = !w_empty && !w_pop;
    assign w_stall_d  = w_wait && (r_starve_cnt == STARVE_LAST);
    assign w_starve_d = (w_wait && !w_stall_d) ? r_starve_cnt + 1'b1 : '0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wb_en      <= 1'b0;
            r_wb_addr    <= REG_ZERO;
            r_wb_data    <= '0;
            r_alu_stall  <= 1'b0;
            r_ld_ready   <= 1'b0;
            r_starve_cnt <= '0;
        end else begin
            r_wb_en      <= w_wb_en_d;
            r_wb_addr    <= w_wb_en_d ? w_src.rd : REG_ZERO;
            r_wb_data    <= w_wb_en_d ? w_src.data : '0;
            r_alu_stall  <= w_stall_d;
            r_ld_ready   <= !w_full_next;
            r_starve_cnt <= w_starve_d;
        end
    end

    // Entries popping this cycle still count as pending: they are not written yet.
    always_comb begin
        w_pend_1 = 1'b0;
        w_pend_2 = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (w_valid[i] && (w_entry_rd[i] == i_rd_addr_1)) begin
                w_pend_1 = 1'b1;
            end
            if (w_valid[i] && (w_entry_rd[i] == i_rd_addr_2)) begin
                w_pend_2 = 1'b1;
            end
        end
    end

    assign o_pend_1 = w_pend_1 && (i_rd_addr_1 != REG_ZERO);
    assign o_pend_2 = w_pend_2 && (i_rd_addr_2 != REG_ZERO);

    assign o_fwd_hit_1  = r_wb_en && (r_wb_addr == i_rd_addr_1) && (i_rd_addr_1 != REG_ZERO);
    assign o_fwd_hit_2  = r_wb_en && (r_wb_addr == i_rd_addr_2) && (i_rd_addr_2 != REG_ZERO);
    assign o_fwd_data_1 = o_fwd_hit_1 ? r_wb_data : '0;
    assign o_fwd_data_2 = o_fwd_hit_2 ? r_wb_data : '0;

    assign o_wb_en     = r_wb_en;
    assign o_wb_addr   = r_wb_addr;
    assign o_wb_data   = r_wb_data;
    assign o_alu_stall = r_alu_stall;
    assign o_ld_ready  = r_ld_ready;

    // The ALU ignoring a stall request breaks the starvation bound.
    a_no_alu_during_stall: assert property (
        @(posedge i_clk) disable iff (i_rst) !(r_alu_stall && i_alu_valid)
    );

endmodule
